// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, two-entry skid buffer
// and synchronous flush that inserts a bubble.
module pipe_stage_skid #(
    parameter int DATA_W      = 96,
    parameter int CTRL_W      = 10,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_fire_s;
    logic              out_fire_s;

    // Ready depends on the state register alone, so out_ready never reaches it.
    assign in_ready   = (state_q != ST_FULL);
    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = main_data_q;
    assign occupancy  = state_q;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid & out_ready;

    // Control payload masking while the stage holds a bubble.
    always_comb begin
        if (ZERO_BUBBLE && (state_q == ST_EMPTY)) begin
            out_ctrl = {CTRL_W{1'b0}};
        end else begin
            out_ctrl = main_ctrl_q;
        end
    end

    // Next-state and payload movement for the head/skid pair.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            // Payload registers are left untouched; only the state empties.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ST_ONE;
                    end else if (in_fire_s) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = ST_FULL;
                    end else if (out_fire_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= {DATA_W{1'b0}};
            main_ctrl_q <= {CTRL_W{1'b0}};
            skid_data_q <= {DATA_W{1'b0}};
            skid_ctrl_q <= {CTRL_W{1'b0}};
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: default parameters (instance a) and a
// narrow ZERO_BUBBLE=0 variant (instance b).
module tb_pipe_stage_skid;

    logic        clk;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
    logic [95:0] a_in_data, a_out_data;
    logic [9:0]  a_in_ctrl, a_out_ctrl;
    logic [1:0]  a_occ;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [7:0]  b_in_data, b_out_data;
    logic [0:0]  b_in_ctrl, b_out_ctrl;
    logic [1:0]  b_occ;

    int n_checks;
    int n_errors;

    pipe_stage_skid #(.DATA_W(96), .CTRL_W(10), .ZERO_BUBBLE(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .flush(a_flush), .occupancy(a_occ)
    );

    pipe_stage_skid #(.DATA_W(8), .CTRL_W(1), .ZERO_BUBBLE(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .flush(b_flush), .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b0;
        a_in_data = '0; a_in_ctrl = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b0;
        b_in_data = '0; b_in_ctrl = '0;

        // Reset state
        #12;
        check("rst_valid", a_out_valid, 1'b0);
        check("rst_occ", a_occ, 2'd0);
        check("rst_ready", a_in_ready, 1'b1);
        check("rst_data", a_out_data, 96'h0);
        check("rst_ctrl", a_out_ctrl, 10'h0);
        check("rst_b_data", b_out_data, 8'h0);
        rst_n = 1'b1;

        // Asynchronous reset mid-operation
        a_in_valid = 1'b1; a_in_data = 96'h11; a_in_ctrl = 10'h155;
        tick();
        a_in_data = 96'h22; a_in_ctrl = 10'h0AA;
        tick();
        a_in_valid = 1'b0;
        check("pre_rst_occ", a_occ, 2'd2);
        check("pre_rst_data", a_out_data, 96'h11);
        check("pre_rst_ctrl", a_out_ctrl, 10'h155);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", a_out_valid, 1'b0);
        check("arst_occ", a_occ, 2'd0);
        check("arst_ready", a_in_ready, 1'b1);
        check("arst_ctrl", a_out_ctrl, 10'h0);
        check("arst_data", a_out_data, 96'h0);
        #2;
        rst_n = 1'b1;

        // Streaming at full throughput
        a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_ctrl = 10'h3FF;
        for (int i = 1; i <= 4; i++) begin
            a_in_data = 96'(i);
            #1;
            check("str_in_ready", a_in_ready, 1'b1);
            tick();
            check("str_valid", a_out_valid, 1'b1);
            check("str_data", a_out_data, 96'(i));
            check("str_ctrl", a_out_ctrl, 10'h3FF);
            check("str_occ", a_occ, 2'd1);
        end
        a_in_valid = 1'b0;
        tick();
        check("str_end_valid", a_out_valid, 1'b0);
        check("str_end_ctrl", a_out_ctrl, 10'h0);
        check("str_end_occ", a_occ, 2'd0);

        // Back-pressure fills the skid register
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_in_data = 96'hA; a_in_ctrl = 10'h00A;
        tick();
        a_in_data = 96'hB; a_in_ctrl = 10'h00B;
        check("bp_ready_one", a_in_ready, 1'b1);
        tick();
        a_in_data = 96'hEE; a_in_ctrl = 10'h0EE;
        check("bp_occ2", a_occ, 2'd2);
        check("bp_ready0", a_in_ready, 1'b0);
        check("bp_head", a_out_data, 96'hA);
        tick();
        a_in_valid = 1'b0;
        check("bp_hold_data", a_out_data, 96'hA);
        check("bp_hold_ctrl", a_out_ctrl, 10'h00A);
        check("bp_hold_occ", a_occ, 2'd2);
        a_out_ready = 1'b1;
        tick();
        check("bp_drain1_data", a_out_data, 96'hB);
        check("bp_drain1_ctrl", a_out_ctrl, 10'h00B);
        check("bp_drain1_occ", a_occ, 2'd1);
        check("bp_drain1_ready", a_in_ready, 1'b1);
        tick();
        check("bp_drain2_occ", a_occ, 2'd0);
        check("bp_drain2_valid", a_out_valid, 1'b0);

        // Simultaneous in/out transfer in ONE
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_in_data = 96'h5; a_in_ctrl = 10'h005;
        tick();
        a_in_data = 96'h6; a_in_ctrl = 10'h006; a_out_ready = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check("sim_occ", a_occ, 2'd1);
        check("sim_data", a_out_data, 96'h6);
        tick();
        check("sim_end_occ", a_occ, 2'd0);

        // Flush in FULL with an offered entry
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_in_data = 96'h8; a_in_ctrl = 10'h008;
        tick();
        a_in_data = 96'h9; a_in_ctrl = 10'h009;
        tick();
        a_in_data = 96'h7; a_in_ctrl = 10'h007; a_flush = 1'b1;
        check("fl_pre_occ", a_occ, 2'd2);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        check("fl_valid", a_out_valid, 1'b0);
        check("fl_occ", a_occ, 2'd0);
        check("fl_ready", a_in_ready, 1'b1);
        check("fl_ctrl", a_out_ctrl, 10'h0);
        tick();
        check("fl_no7_valid", a_out_valid, 1'b0);

        // Flush in ONE discards a concurrent in_fire, then accept resumes
        a_out_ready = 1'b0; a_in_valid = 1'b1;
        a_in_data = 96'h8; a_in_ctrl = 10'h008;
        tick();
        a_in_data = 96'h7; a_in_ctrl = 10'h007; a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        check("fl1_occ", a_occ, 2'd0);
        check("fl1_valid", a_out_valid, 1'b0);
        a_in_data = 96'h3C; a_in_ctrl = 10'h03C;
        tick();
        a_in_valid = 1'b0;
        check("fl1_new_valid", a_out_valid, 1'b1);
        check("fl1_new_data", a_out_data, 96'h3C);
        check("fl1_new_ctrl", a_out_ctrl, 10'h03C);

        // Narrow variant: streaming, stale ctrl visible in bubble
        b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_ctrl = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b_in_data = 8'(i);
            tick();
            check("b_str_data", b_out_data, 8'(i));
            check("b_str_valid", b_out_valid, 1'b1);
            check("b_str_ready", b_in_ready, 1'b1);
        end
        b_in_valid = 1'b0;
        tick();
        check("b_str_end_valid", b_out_valid, 1'b0);
        check("b_str_stale_ctrl", b_out_ctrl, 1'b1);
        check("b_str_stale_data", b_out_data, 8'h4);

        // Narrow variant: back-pressure
        b_out_ready = 1'b0; b_in_valid = 1'b1;
        b_in_data = 8'h0A; b_in_ctrl = 1'b0;
        tick();
        b_in_data = 8'h0B; b_in_ctrl = 1'b1;
        tick();
        b_in_valid = 1'b0;
        check("b_bp_occ2", b_occ, 2'd2);
        check("b_bp_ready0", b_in_ready, 1'b0);
        check("b_bp_head", b_out_data, 8'h0A);
        check("b_bp_head_ctrl", b_out_ctrl, 1'b0);
        b_out_ready = 1'b1;
        tick();
        check("b_bp_d1_data", b_out_data, 8'h0B);
        check("b_bp_d1_occ", b_occ, 2'd1);
        tick();
        check("b_bp_d2_occ", b_occ, 2'd0);
        check("b_bp_d2_valid", b_out_valid, 1'b0);
        check("b_bp_stale_ctrl", b_out_ctrl, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register for the MIPS datapath. It generalises the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block with these features:
- separate data and control payloads of configurable width;
- valid/ready handshaking with a two-entry skid buffer, so back-pressure never creates a combinational path from `out_ready` to `in_ready`;
- synchronous flush that inserts a bubble and zeroes control signals.

## Interface
Parameters:
- `DATA_W`, 96: width of the data payload (read data, immediate, next PC, register numbers, packed by the instantiating stage).
- `CTRL_W`, 10: width of the control payload (RegWrite, MemRead, MemWrite, Branch, ALUOp, …).
- `ZERO_BUBBLE`, 1: when 1, `out_ctrl` is forced to 0 whenever `out_valid` = 0. When 0, `out_ctrl` shows the stale register contents.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream stage presents a valid entry.
- `in_ready` out 1: block can accept an entry this cycle.
- `in_data` in DATA_W: upstream data payload.
- `in_ctrl` in CTRL_W: upstream control payload.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: downstream accepts the head entry.
- `out_data` out DATA_W: head data payload.
- `out_ctrl` out CTRL_W: head control payload, masked per `ZERO_BUBBLE`.
- `flush` in 1: synchronous kill of all held entries (branch taken, exception).
- `occupancy` out 2: number of held entries (0, 1 or 2).

## Operation
- Handshake definitions:
  - input transfer (in_fire) = `in_valid & in_ready`;
  - output transfer (out_fire) = `out_valid & out_ready`.
- Storage:
  - main register (head) and skid register, each holding `{data, ctrl}`;
  - a 2-bit state: EMPTY = 0, ONE = 1, FULL = 2. `occupancy` equals the state.
- Output decode:
  - `out_valid` = (state != EMPTY);
  - `out_data` = main data;
  - `in_ready` = (state != FULL), decoded only from the state register.
- Transitions without flush:
  - EMPTY, in_fire: main <= in; go to ONE.
  - EMPTY, no in_fire: stay in EMPTY.
  - ONE, in_fire and out_fire: main <= in; stay in ONE.
  - ONE, in_fire without out_fire: skid <= in; go to FULL.
  - ONE, out_fire without in_fire: go to EMPTY.
  - ONE, neither: hold.
  - FULL (in_ready = 0), out_fire: main <= skid; go to ONE.
  - FULL, no out_fire: hold.
- Ordering: entries leave strictly in arrival order. No entry is duplicated or lost except by flush.
- Flush:
  - takes priority over every handshake; the next state is EMPTY;
  - any in_fire in the flush cycle is discarded;
  - an out_fire in the flush cycle is still seen by downstream as a transfer;
  - data registers are not cleared.
- Stability: while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_ctrl` are held bit-stable.

## Timing
- Reset (`rst_n` low, takes effect immediately, independent of `clk`):
  - state = EMPTY, so `out_valid` = 0 and `occupancy` = 0;
  - `in_ready` = 1;
  - main and skid registers = 0, so `out_data` = 0 and `out_ctrl` = 0.
- Reset mid-operation drops all entries with no partial transfer. The first accept is possible on the first rising edge after `rst_n` deasserts.
- Latency: an entry accepted at edge k appears with `out_valid` = 1 after edge k, i.e. in the cycle after acceptance.
- Throughput: 1 entry/cycle sustained while `out_ready` = 1.
- Back-pressure:
  - `in_ready` falls one cycle after the downstream stall that fills the skid register;
  - the skid register absorbs the one extra entry accepted in that cycle.
- No combinational path from `out_ready` or `flush` to `in_ready`. The only combinational output path is register → `out_ctrl` through the `ZERO_BUBBLE` mask.
- Flush asserted at edge k: after edge k, `out_valid` = 0, `occupancy` = 0 and `in_ready` = 1. New entries are accepted from edge k+1.

## Test plan
- Reset: stream data 0x11, 0x22 with `out_ready` = 0, then pull `rst_n` low between clock edges. Required: `out_valid` = 0, `occupancy` = 0, `in_ready` = 1 and `out_ctrl` = 0 immediately, without waiting for a clock edge.
- Streaming: `out_ready` = 1 and `in_valid` = 1 for 4 cycles with data 1, 2, 3, 4 (ctrl 0x3FF). Required: the same sequence on `out_data` one cycle later, and `in_ready` stays 1 throughout.
- Back-pressure: send A = 0xA, then B = 0xB with `out_ready` = 0. Required:
  - `occupancy` = 2, `in_ready` = 0 and `out_data` = 0xA held;
  - on raising `out_ready`: A, then B, with `occupancy` going 2→1→0.
- Simultaneous transfers in ONE: head 0x5, then in_fire (0x6) together with out_fire. Required: `occupancy` stays 1 and `out_data` = 0x6 next cycle.
- Flush in FULL, with `in_valid` = 1 (data 0x7) in the same cycle. Required:
  - next cycle `out_valid` = 0, `occupancy` = 0 and `out_ctrl` = 0 (ZERO_BUBBLE = 1);
  - 0x7 never appears on `out_data`.
- Parameter sweep: DATA_W = 8, CTRL_W = 1, ZERO_BUBBLE = 0, running the streaming and back-pressure scenarios. Required: identical ordering, and `out_ctrl` shows the stale value while `out_valid` = 0.
